// File: rtl/response_checker_if.sv
// ---------------------------------------------------------------------------
// response_checker_if
// Bundles the run-control, response, expected-data and result signals of the
// response checker.
//   master : test environment side (drives start, y, exp_data and the valids)
//   slave  : checker side (drives exp_ready, busy, done, pass, mismatch_count,
//            first_fail_idx, overflow, signature)
// Parameter Y_WIDTH : width of the response and expected words.
// ---------------------------------------------------------------------------
interface response_checker_if #(
  parameter int Y_WIDTH = 192
);
  logic               start;
  logic [Y_WIDTH-1:0] y;
  logic               y_valid;
  logic [Y_WIDTH-1:0] exp_data;
  logic               exp_valid;
  logic               exp_ready;
  logic               busy;
  logic               done;
  logic               pass;
  logic [15:0]        mismatch_count;
  logic [15:0]        first_fail_idx;
  logic               overflow;
  logic [31:0]        signature;

  modport master (
    output start, y, y_valid, exp_data, exp_valid,
    input  exp_ready, busy, done, pass, mismatch_count, first_fail_idx,
           overflow, signature
  );

  modport slave (
    input  start, y, y_valid, exp_data, exp_valid,
    output exp_ready, busy, done, pass, mismatch_count, first_fail_idx,
           overflow, signature
  );
endinterface

// File: rtl/response_checker.sv
// ---------------------------------------------------------------------------
// response_checker
// Captures NUM_VECTORS response words into a small FIFO and compares each one
// against a golden word offered on the exp_data/exp_valid/exp_ready handshake.
// Reports mismatch count, first failing index, FIFO overflow and pass/fail.
//
// Ports:
//   clk  : clock, all state changes on the rising edge
//   rst  : synchronous active-high reset, highest priority
//   bus  : response_checker_if.slave
//          in : start, y, y_valid, exp_data, exp_valid
//          out: exp_ready, busy, done, pass, mismatch_count, first_fail_idx,
//               overflow, signature
//
// Build option: define RESP_CHECK_MISR_EN to compact every captured response
// into a 32-bit MISR signature; otherwise signature is constant 32'hFFFFFFFF.
// ---------------------------------------------------------------------------
module response_checker #(
  parameter int Y_WIDTH     = 192,
  parameter int NUM_VECTORS = 21,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic               clk,
  input  logic               rst,
  response_checker_if.slave  bus
);

  localparam int                PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int                CNT_W   = PTR_W + 1;
  localparam logic [15:0]       NUM_V   = 16'(NUM_VECTORS);
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0]  PTR_MAX = PTR_W'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  state_t             state_nxt;

  logic [Y_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   occ;
  logic [15:0]        capture_idx;
  logic [15:0]        compare_idx;
  logic [15:0]        mismatch_count;
  logic [15:0]        first_fail_idx;
  logic               overflow;

  logic               fifo_empty;
  logic               fifo_full;
  logic               capture;
  logic               push;
  logic               pop;
  logic               miscompare;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_MAX) ? '0 : p + PTR_W'(1);
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign fifo_empty = (occ == '0);
  assign fifo_full  = (occ == DEPTH_C);

  // A start pulse in RUN restarts the run, so any capture or compare offered
  // in that same cycle is discarded.
  assign capture    = (state == RUN) && !bus.start && bus.y_valid && (capture_idx < NUM_V);
  assign pop        = (state == RUN) && !bus.start && bus.exp_valid && !fifo_empty;
  // A full FIFO still accepts the word when the head leaves in the same cycle.
  assign push       = capture && (!fifo_full || pop);
  assign miscompare = pop && (fifo_mem[rd_ptr] != bus.exp_data);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (bus.start) state_nxt = RUN;
      RUN: begin
        if (bus.start) begin
          state_nxt = RUN;
        end else if ((compare_idx == NUM_V) ||
                     (overflow && (capture_idx == NUM_V) && fifo_empty)) begin
          // Dropped words never reach the compare side, so an overflowed run
          // ends once everything captured has drained.
          state_nxt = DONE;
        end
      end
      DONE: if (bus.start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus.exp_ready = (state == RUN) && !fifo_empty;
    bus.busy      = (state == RUN);
    bus.done      = (state == DONE);
    bus.pass      = (state == DONE) && (mismatch_count == 16'd0) && !overflow;
  end

  assign bus.mismatch_count = mismatch_count;
  assign bus.first_fail_idx = first_fail_idx;
  assign bus.overflow       = overflow;

  // Run bookkeeping: FIFO pointers, counters and compare results
  always_ff @(posedge clk) begin
    if (rst || bus.start) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      occ            <= '0;
      capture_idx    <= '0;
      compare_idx    <= '0;
      mismatch_count <= '0;
      first_fail_idx <= 16'hFFFF;
      overflow       <= 1'b0;
    end else if (state == RUN) begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop) begin
        occ <= occ + CNT_W'(1);
      end else if (pop && !push) begin
        occ <= occ - CNT_W'(1);
      end
      if (capture) capture_idx <= capture_idx + 16'd1;
      if (capture && !push) overflow <= 1'b1;
      if (pop) compare_idx <= compare_idx + 16'd1;
      if (miscompare) begin
        mismatch_count <= sat_inc(mismatch_count);
        if (first_fail_idx == 16'hFFFF) first_fail_idx <= compare_idx;
      end
    end
  end

  // FIFO storage carries data only and needs no reset
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= bus.y;
  end

`ifdef RESP_CHECK_MISR_EN
  localparam int CHUNKS = (Y_WIDTH + 31) / 32;

  logic [31:0] signature;

  // XOR-fold the response into 32-bit chunks; the top chunk is zero-padded.
  function automatic logic [31:0] fold32(input logic [Y_WIDTH-1:0] v);
    logic [CHUNKS*32-1:0] padded;
    logic [31:0]          acc;
    padded              = '0;
    padded[Y_WIDTH-1:0] = v;
    acc                 = '0;
    for (int i = 0; i < CHUNKS; i++) acc = acc ^ padded[i*32 +: 32];
    return acc;
  endfunction

  function automatic logic [31:0] misr_step(input logic [31:0] s, input logic [31:0] d);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]} ^ d;
  endfunction

  // Every captured word is compacted, including words dropped on overflow.
  always_ff @(posedge clk) begin
    if (rst || bus.start) begin
      signature <= 32'hFFFF_FFFF;
    end else if (capture) begin
      signature <= misr_step(signature, fold32(bus.y));
    end
  end

  assign bus.signature = signature;
`else
  assign bus.signature = 32'hFFFF_FFFF;
`endif

endmodule

// File: tb/tb_response_checker.sv
module tb_response_checker;

  localparam int YW    = 192;
  localparam int NV    = 21;
  localparam int DEPTH = 4;

  typedef struct {
    string name;
    int    flip;
    int    hold;
    int    yprob;
    int    eprob;
    int    restart_at;
    int    e_mm;
    int    e_ff;
    int    e_pass;
    int    e_ovf;
  } scn_t;

  logic clk;
  logic rst;

  response_checker_if #(.Y_WIDTH(YW)) bus ();

  response_checker #(
    .Y_WIDTH    (YW),
    .NUM_VECTORS(NV),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  bit fired;

  logic [YW-1:0] w [NV];
  scn_t          tbl [11];

  // Reference model: a queue stands in for the buffer, plain integers for
  // the counters; state 0 = idle, 1 = running, 2 = finished.
  int            m_st;
  logic [YW-1:0] mq [$];
  int            m_cap, m_cmp, m_mm, m_ff;
  bit            m_ovf;
  logic [31:0]   m_sig;

`ifdef RESP_CHECK_MISR_EN
  function automatic logic [31:0] misr_ref(input logic [31:0] s, input logic [YW-1:0] v);
    logic [31:0] f;
    logic        fb;
    f = '0;
    for (int b = 0; b < YW; b++) f[b % 32] = f[b % 32] ^ v[b];
    fb = s[31] ^ s[21] ^ s[1] ^ s[0];
    return {s[30:0], fb} ^ f;
  endfunction
`endif

  task automatic model_clear();
    mq.delete();
    m_cap = 0; m_cmp = 0; m_mm = 0; m_ff = 65535; m_ovf = 0;
    m_sig = 32'hFFFF_FFFF;
  endtask

  task automatic model_edge();
    bit            pop, full0, ndone;
    logic [YW-1:0] h;
    if (rst) begin
      m_st = 0;
      model_clear();
    end else if (bus.start) begin
      m_st = 1;
      model_clear();
    end else if (m_st == 1) begin
      ndone = (m_cmp == NV) || (m_ovf && m_cap == NV && mq.size() == 0);
      full0 = (mq.size() == DEPTH);
      pop   = bus.exp_valid && (mq.size() > 0);
      if (pop) begin
        h = mq.pop_front();
        if (h !== bus.exp_data) begin
          if (m_mm < 65535) m_mm++;
          if (m_ff == 65535) m_ff = m_cmp;
        end
        m_cmp++;
      end
      if (bus.y_valid && m_cap < NV) begin
        if (!full0 || pop) mq.push_back(bus.y);
        else               m_ovf = 1;
        m_cap++;
`ifdef RESP_CHECK_MISR_EN
        m_sig = misr_ref(m_sig, bus.y);
`endif
      end
      if (ndone) m_st = 2;
    end
  endtask

  function automatic logic [68:0] model_vec();
    logic rdy, bsy, dn, ps;
    rdy = (m_st == 1) && (mq.size() > 0);
    bsy = (m_st == 1);
    dn  = (m_st == 2);
    ps  = dn && (m_mm == 0) && !m_ovf;
    return {rdy, bsy, dn, ps, m_ovf, 16'(m_mm), 16'(m_ff), m_sig};
  endfunction

  function automatic logic [68:0] dut_vec();
    return {bus.exp_ready, bus.busy, bus.done, bus.pass, bus.overflow,
            bus.mismatch_count, bus.first_fail_idx, bus.signature};
  endfunction

  task automatic check_vec(input string nm, input logic [68:0] got, input logic [68:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, got, want);
    end
  endtask

  task automatic check_int(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, got, want);
    end
  endtask

  // One clock: advance the model on the pre-edge inputs, then compare all
  // outputs shortly after the edge.
  task automatic step();
    model_edge();
    fired = bus.exp_valid && bus.exp_ready;
    @(posedge clk);
    #1;
    cyc++;
    check_vec("cycle", dut_vec(), model_vec());
  endtask

  task automatic gen_words();
    for (int i = 0; i < NV; i++)
      for (int j = 0; j < YW; j++) w[i][j] = 1'($urandom_range(1));
  endtask

  function automatic scn_t mk(string nm, int flip, int hold, int yp, int ep, int rs,
                              int mm, int ff, int ps, int ov);
    scn_t s;
    s.name = nm; s.flip = flip; s.hold = hold; s.yprob = yp; s.eprob = ep;
    s.restart_at = rs; s.e_mm = mm; s.e_ff = ff; s.e_pass = ps; s.e_ovf = ov;
    return s;
  endfunction

  task automatic run_scn(input scn_t s);
    int yi, ei, k;
    gen_words();
    bus.start = 1'b1; bus.y_valid = 1'b0; bus.exp_valid = 1'b0;
    step();
    bus.start = 1'b0;
    yi = 0; ei = 0; k = 0;
    while (!bus.done && k < 600) begin
      bus.start     = (k == s.restart_at);
      bus.y_valid   = (yi < NV) && ($urandom_range(99) < s.yprob);
      bus.y         = (yi < NV) ? w[yi] : '0;
      bus.exp_valid = (k >= s.hold) && (ei < NV) && ($urandom_range(99) < s.eprob);
      bus.exp_data  = (ei < NV) ? (w[ei] ^ {{(YW-1){1'b0}}, (ei == s.flip)}) : '0;
      step();
      if (bus.y_valid && yi < NV) yi++;
      if (fired) ei++;
      if (k == s.restart_at) begin yi = 0; ei = 0; end
      k++;
    end
    bus.start = 1'b0; bus.y_valid = 1'b0; bus.exp_valid = 1'b0;
    n_vec++;
    if (!bus.done) begin
      n_err++;
      $display("FAIL %s_timeout done=%0b required=1", s.name, bus.done);
    end
    if (s.e_mm >= 0)   check_int({s.name, "_mm"},   32'(bus.mismatch_count), 32'(s.e_mm));
    if (s.e_ff >= 0)   check_int({s.name, "_ff"},   32'(bus.first_fail_idx), 32'(s.e_ff));
    if (s.e_pass >= 0) check_int({s.name, "_pass"}, 32'(bus.pass),           32'(s.e_pass));
    if (s.e_ovf >= 0)  check_int({s.name, "_ovf"},  32'(bus.overflow),       32'(s.e_ovf));
    // done must hold while idle
    step();
    step();
  endtask

  initial begin
    logic [68:0] rst_vec;
    int          ei;

    tbl[0] = mk("all_match",    -1, 0, 100, 100, -1,  0, 'hFFFF, 1, 0);
    tbl[1] = mk("one_flip",      5, 0, 100, 100, -1,  1,      5, 0, 0);
    // Four words fill the buffer, the fifth is dropped; afterwards every pop
    // is one word ahead of the golden stream, so compares 4..19 all differ.
    tbl[2] = mk("backpressure", -1, 5, 100, 100, -1, 16,      4, 0, 1);
    tbl[3] = mk("full_pushpop", -1, 4, 100, 100, -1,  0, 'hFFFF, 1, 0);
    tbl[4] = mk("restart",      -1, 0, 100, 100,  6,  0, 'hFFFF, 1, 0);
    for (int i = 5; i < 11; i++)
      tbl[i] = mk("random", $urandom_range(0, 25), $urandom_range(0, 8),
                  $urandom_range(40, 100), $urandom_range(30, 100),
                  ($urandom_range(3) == 0) ? $urandom_range(1, 30) : -1,
                  -1, -1, -1, -1);

    rst = 1'b1;
    bus.start = 1'b0; bus.y = '0; bus.y_valid = 1'b0;
    bus.exp_data = '0; bus.exp_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();

    for (int i = 0; i < 11; i++) run_scn(tbl[i]);

    // Reset in the middle of a run, with start and both valids asserted.
    gen_words();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    ei = 0;
    for (int i = 0; i < 10; i++) begin
      bus.y_valid = 1'b1; bus.y = w[i];
      bus.exp_valid = 1'b1; bus.exp_data = w[ei];
      step();
      if (fired) ei++;
    end
    rst = 1'b1; bus.start = 1'b1;
    step();
    rst_vec = {5'b0, 16'h0000, 16'hFFFF, 32'hFFFF_FFFF};
    check_vec("reset_midrun", dut_vec(), rst_vec);
    rst = 1'b0; bus.start = 1'b0; bus.y_valid = 1'b0; bus.exp_valid = 1'b0;
    step();
    run_scn(tbl[0]);

`ifdef RESP_CHECK_MISR_EN
    // From all ones the feedback tap sum is 0, so one rotation gives
    // FFFFFFFE; folding in a 1 then sets bit 0 again.
    bus.start = 1'b1; step(); bus.start = 1'b0;
    bus.y = '0; bus.y_valid = 1'b1; step(); bus.y_valid = 1'b0;
    check_int("misr_zero", bus.signature, 32'hFFFF_FFFE);
    bus.start = 1'b1; step(); bus.start = 1'b0;
    bus.y = {{(YW-1){1'b0}}, 1'b1}; bus.y_valid = 1'b1; step(); bus.y_valid = 1'b0;
    check_int("misr_one", bus.signature, 32'hFFFF_FFFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
